// File: rtl/doorlock_pkg.sv
// Shared definitions for the door-lock datapath: digit/length widths,
// default sizing constants and the digit-pulse decode helpers.
package doorlock_pkg;

   localparam int DIGIT_W     = 4;
   localparam int LEN_W       = 4;
   localparam int ERR_W       = 4;
   localparam int DIGIT_N     = 10;

   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_MIN_LEN = 4;
   localparam int DEF_MAX_ERR = 10;

   typedef logic [DIGIT_W-1:0] digit_t;

   // True when exactly one digit button pulse is present.
   function automatic logic is_onehot(input logic [DIGIT_N-1:0] v);
      return ($countones(v) == 1);
   endfunction

   // Index of the set bit; only meaningful when is_onehot(v) holds.
   function automatic digit_t onehot_to_digit(input logic [DIGIT_N-1:0] v);
      digit_t d;
      d = {DIGIT_W{1'b0}};
      for (int k = 0; k < DIGIT_N; k++) begin
         if (v[k]) begin
            d = DIGIT_W'(k);
         end else begin
            d = d;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/psw_entry_store_psw_array.sv
// Append-only digit array with a length counter. Used for both the stored
// password (mem) and the attempt buffer (buff). A clear wins over an append;
// an append to a full array is ignored.
module psw_array
   import doorlock_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sl,
   input  logic                       clr,
   input  digit_t                     din,
   output logic [LEN_W-1:0]           len,
   output logic [MAX_LEN*DIGIT_W-1:0] data
);

   logic [LEN_W-1:0]           len_r;
   logic [MAX_LEN*DIGIT_W-1:0] data_r;
   logic                       full_s;

   assign full_s = (len_r == LEN_W'(MAX_LEN));

   // Clear, append at the current length, or hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_r  <= {LEN_W{1'b0}};
         data_r <= {(MAX_LEN*DIGIT_W){1'b0}};
      end else if (clr) begin
         len_r  <= {LEN_W{1'b0}};
         data_r <= {(MAX_LEN*DIGIT_W){1'b0}};
      end else if (sl && !full_s) begin
         data_r[len_r*DIGIT_W +: DIGIT_W] <= din;
         len_r                            <= len_r + 4'd1;
      end else begin
         len_r  <= len_r;
         data_r <= data_r;
      end
   end

   assign len  = len_r;
   assign data = data_r;

endmodule

// File: rtl/psw_entry_store.sv
// Password entry store: decodes the one-hot digit pulse, appends digits to
// the stored password (mem) or the attempt buffer (buff), and reports the
// comparison/limit/error status to the control FSM.
// Optional build macro PSW_BUFF_AUTOCLR_EN: when defined, buff is cleared on
// the edge following every compare strobe.
module psw_entry_store
   import doorlock_pkg::*;
#(
   parameter int           MAX_LEN    = DEF_MAX_LEN,
   parameter int           MIN_LEN    = DEF_MIN_LEN,
   // First digit is nibble MASTER_LEN-1 of this vector, last digit is nibble 0.
   parameter logic [59:0]  MASTER_PSW = 60'h000_0000_1234_5678,
   parameter int           MASTER_LEN = 8,
   parameter int           MAX_ERR    = DEF_MAX_ERR
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [9:0]       digit_in,
   input  logic             decision,
   input  logic             mem_sl,
   input  logic             buff_sl,
   input  logic             mem_rst,
   input  logic             buff_rst,
   input  logic             compare,
   output logic             input_valid,
   output logic             limit,
   output logic             same,
   output logic             master_same,
   output logic [ERR_W-1:0] error_num,
   output logic             lockout,
   output logic [LEN_W-1:0] mem_len,
   output logic [LEN_W-1:0] buff_len
);

   logic                       legal_s;
   digit_t                     new_digit_s;
   digit_t                     digit_r;
   logic                       pending_r;
   logic                       input_valid_r;
   logic [ERR_W-1:0]           error_num_r;

   logic                       mem_sel_s;
   logic                       buff_sel_s;
   logic                       buff_clr_s;
   logic                       mem_full_s;
   logic                       buff_full_s;
   logic                       consume_s;

   logic [LEN_W-1:0]           mem_len_s;
   logic [LEN_W-1:0]           buff_len_s;
   logic [MAX_LEN*DIGIT_W-1:0] mem_data_s;
   logic [MAX_LEN*DIGIT_W-1:0] buff_data_s;

   logic                       same_s;
   logic                       master_same_s;

   assign legal_s     = is_onehot(digit_in);
   assign new_digit_s = onehot_to_digit(digit_in);

   assign mem_full_s  = (mem_len_s == LEN_W'(MAX_LEN));
   assign buff_full_s = (buff_len_s == LEN_W'(MAX_LEN));

   // A select only acts on a digit that is still waiting to be stored.
   assign mem_sel_s   = mem_sl & pending_r;
   assign buff_sel_s  = buff_sl & pending_r;

`ifdef PSW_BUFF_AUTOCLR_EN
   logic autoclr_r;

   // Remember a compare so buff is wiped on the following edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         autoclr_r <= 1'b0;
      end else begin
         autoclr_r <= compare;
      end
   end

   assign buff_clr_s = buff_rst | autoclr_r;
`else
   assign buff_clr_s = buff_rst;
`endif

   // The pending digit is used up by a real append, or discarded when a
   // clear overrides a select to the same array.
   assign consume_s = (mem_sel_s  & (mem_rst    | ~mem_full_s)) |
                      (buff_sel_s & (buff_clr_s | ~buff_full_s));

   // Digit capture, pending flag and the one-cycle input_valid pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_r       <= {DIGIT_W{1'b0}};
         pending_r     <= 1'b0;
         input_valid_r <= 1'b0;
      end else begin
         input_valid_r <= legal_s;
         if (legal_s) begin
            digit_r   <= new_digit_s;
            pending_r <= 1'b1;
         end else if (consume_s) begin
            digit_r   <= digit_r;
            pending_r <= 1'b0;
         end else begin
            digit_r   <= digit_r;
            pending_r <= pending_r;
         end
      end
   end

   psw_array #(.MAX_LEN(MAX_LEN)) u_mem (
      .clk  (clk),
      .rst_n(rst_n),
      .sl   (mem_sel_s),
      .clr  (mem_rst),
      .din  (digit_r),
      .len  (mem_len_s),
      .data (mem_data_s)
   );

   psw_array #(.MAX_LEN(MAX_LEN)) u_buff (
      .clk  (clk),
      .rst_n(rst_n),
      .sl   (buff_sel_s),
      .clr  (buff_clr_s),
      .din  (digit_r),
      .len  (buff_len_s),
      .data (buff_data_s)
   );

   // buff vs mem equality over the occupied part of mem.
   always_comb begin
      logic eq_v;
      eq_v = 1'b1;
      for (int i = 0; i < MAX_LEN; i++) begin
         eq_v = eq_v & ((LEN_W'(i) >= mem_len_s) |
                        (mem_data_s[i*DIGIT_W +: DIGIT_W] == buff_data_s[i*DIGIT_W +: DIGIT_W]));
      end
      same_s = (buff_len_s == mem_len_s) & (mem_len_s >= LEN_W'(MIN_LEN)) & eq_v;
   end

   // buff vs the fixed master code.
   always_comb begin
      logic meq_v;
      meq_v = 1'b1;
      for (int i = 0; i < MASTER_LEN; i++) begin
         meq_v = meq_v & (buff_data_s[i*DIGIT_W +: DIGIT_W] ==
                          MASTER_PSW[(MASTER_LEN-1-i)*DIGIT_W +: DIGIT_W]);
      end
      master_same_s = (buff_len_s == LEN_W'(MASTER_LEN)) & meq_v;
   end

   // Consecutive failed-attempt counter, saturating; mem_rst wins over compare.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         error_num_r <= {ERR_W{1'b0}};
      end else if (mem_rst) begin
         error_num_r <= {ERR_W{1'b0}};
      end else if (compare) begin
         if (same_s || master_same_s) begin
            error_num_r <= {ERR_W{1'b0}};
         end else if (error_num_r == 4'hF) begin
            error_num_r <= 4'hF;
         end else begin
            error_num_r <= error_num_r + 4'd1;
         end
      end else begin
         error_num_r <= error_num_r;
      end
   end

   assign input_valid = input_valid_r;
   assign limit       = decision ? mem_full_s : buff_full_s;
   assign same        = same_s;
   assign master_same = master_same_s;
   assign error_num   = error_num_r;
   assign lockout     = (error_num_r >= ERR_W'(MAX_ERR));
   assign mem_len     = mem_len_s;
   assign buff_len    = buff_len_s;

endmodule

// File: tb/tb_psw_entry_store.sv
// Scoreboard bench for psw_entry_store: expectations are queued while the
// stimulus is driven and checked once the DUT has reacted.
module tb_psw_entry_store;

   localparam int S_IV   = 0;
   localparam int S_LIM  = 1;
   localparam int S_SAME = 2;
   localparam int S_MS   = 3;
   localparam int S_ERR  = 4;
   localparam int S_LOCK = 5;
   localparam int S_MLEN = 6;
   localparam int S_BLEN = 7;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] digit_in = 10'd0;
   logic       decision = 1'b0;
   logic       mem_sl = 1'b0;
   logic       buff_sl = 1'b0;
   logic       mem_rst = 1'b0;
   logic       buff_rst = 1'b0;
   logic       compare = 1'b0;
   logic       input_valid;
   logic       limit;
   logic       same;
   logic       master_same;
   logic [3:0] error_num;
   logic       lockout;
   logic [3:0] mem_len;
   logic [3:0] buff_len;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string tag;
      int    sig;
      int    val;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   psw_entry_store dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .digit_in   (digit_in),
      .decision   (decision),
      .mem_sl     (mem_sl),
      .buff_sl    (buff_sl),
      .mem_rst    (mem_rst),
      .buff_rst   (buff_rst),
      .compare    (compare),
      .input_valid(input_valid),
      .limit      (limit),
      .same       (same),
      .master_same(master_same),
      .error_num  (error_num),
      .lockout    (lockout),
      .mem_len    (mem_len),
      .buff_len   (buff_len)
   );

   function automatic int sample(input int sig);
      case (sig)
         S_IV:    return int'(input_valid);
         S_LIM:   return int'(limit);
         S_SAME:  return int'(same);
         S_MS:    return int'(master_same);
         S_ERR:   return int'(error_num);
         S_LOCK:  return int'(lockout);
         S_MLEN:  return int'(mem_len);
         S_BLEN:  return int'(buff_len);
         default: return -1;
      endcase
   endfunction

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string tag, input int sig, input int val);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_eq(e.tag, sample(e.sig), e.val);
      end
   endtask

   // One clock: inputs already set, check queued expectations, drop strobes.
   task automatic tick();
      @(posedge clk);
      #1;
      drain();
      digit_in = 10'd0;
      mem_sl   = 1'b0;
      buff_sl  = 1'b0;
      mem_rst  = 1'b0;
      buff_rst = 1'b0;
      compare  = 1'b0;
   endtask

   // Enter digit d, then select it into mem and/or buff.
   task automatic put(input int d, input bit to_mem, input bit to_buff);
      digit_in = 10'b1 << d;
      expect_out("input_valid_pulse", S_IV, 1);
      tick();
      mem_sl  = to_mem;
      buff_sl = to_buff;
      expect_out("input_valid_one_cycle", S_IV, 0);
      tick();
   endtask

   task automatic clear_both();
      mem_rst  = 1'b1;
      buff_rst = 1'b1;
      expect_out("clr_mem_len", S_MLEN, 0);
      expect_out("clr_buff_len", S_BLEN, 0);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      expect_out("rst_iv", S_IV, 0);
      expect_out("rst_limit", S_LIM, 0);
      expect_out("rst_same", S_SAME, 0);
      expect_out("rst_master", S_MS, 0);
      expect_out("rst_err", S_ERR, 0);
      expect_out("rst_lock", S_LOCK, 0);
      expect_out("rst_mlen", S_MLEN, 0);
      expect_out("rst_blen", S_BLEN, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Reset mid-entry is asynchronous
      put(1, 1'b1, 1'b0);
      put(2, 1'b1, 1'b0);
      put(3, 1'b1, 1'b0);
      check_eq("mid_mlen_before", int'(mem_len), 3);
      rst_n = 1'b0;
      #2;
      expect_out("async_mlen", S_MLEN, 0);
      expect_out("async_iv", S_IV, 0);
      expect_out("async_err", S_ERR, 0);
      drain();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Set and confirm
      for (int i = 1; i <= 4; i++) put(i, 1'b1, 1'b0);
      for (int i = 1; i <= 4; i++) put(i, 1'b0, 1'b1);
      expect_out("set_mlen", S_MLEN, 4);
      expect_out("set_blen", S_BLEN, 4);
      expect_out("same_match", S_SAME, 1);
      expect_out("master_no", S_MS, 0);
      drain();
      buff_rst = 1'b1;
      tick();
      put(1, 1'b0, 1'b1);
      put(2, 1'b0, 1'b1);
      put(3, 1'b0, 1'b1);
      put(5, 1'b0, 1'b1);
      expect_out("same_diff_digit", S_SAME, 0);
      drain();
      clear_both();
      for (int i = 1; i <= 3; i++) put(i, 1'b1, 1'b0);
      for (int i = 1; i <= 3; i++) put(i, 1'b0, 1'b1);
      expect_out("same_below_min", S_SAME, 0);
      expect_out("short_blen", S_BLEN, 3);
      drain();

      // Limit
      clear_both();
      decision = 1'b1;
      for (int i = 0; i < 8; i++) put(i, 1'b1, 1'b0);
      expect_out("limit_mem_full", S_LIM, 1);
      expect_out("mlen_full", S_MLEN, 8);
      drain();
      put(9, 1'b1, 1'b0);
      expect_out("mlen_no_overflow", S_MLEN, 8);
      drain();
      decision = 1'b0;
      put(4, 1'b0, 1'b1);
      put(6, 1'b0, 1'b1);
      expect_out("limit_buff_2", S_LIM, 0);
      expect_out("blen_2", S_BLEN, 2);
      drain();

      // Illegal and overlap
      digit_in = 10'b0000000011;
      expect_out("illegal_no_iv", S_IV, 0);
      tick();
      buff_sl = 1'b1;
      expect_out("illegal_no_pending", S_BLEN, 2);
      tick();
      digit_in = 10'b1 << 7;
      tick();
      digit_in = 10'b1 << 3;
      buff_sl  = 1'b1;
      expect_out("overlap_blen", S_BLEN, 3);
      expect_out("overlap_iv", S_IV, 1);
      tick();
      buff_sl = 1'b1;
      expect_out("overlap_pending_kept", S_BLEN, 4);
      tick();

      // Errors
      for (int i = 1; i <= 10; i++) begin
         compare = 1'b1;
         expect_out("err_count", S_ERR, i);
         expect_out("lockout_edge", S_LOCK, (i >= 10) ? 1 : 0);
         tick();
      end
      for (int i = 1; i <= 7; i++) begin
         compare = 1'b1;
         expect_out("err_saturate", S_ERR, (10 + i > 15) ? 15 : 10 + i);
         tick();
      end

      // Master code, digits 3 and 4 entered through an overlapping pulse
      buff_rst = 1'b1;
      tick();
      put(1, 1'b0, 1'b1);
      put(2, 1'b0, 1'b1);
      digit_in = 10'b1 << 3;
      tick();
      digit_in = 10'b1 << 4;
      buff_sl  = 1'b1;
      tick();
      buff_sl = 1'b1;
      tick();
      for (int i = 5; i <= 8; i++) put(i, 1'b0, 1'b1);
      expect_out("master_blen", S_BLEN, 8);
      expect_out("master_same", S_MS, 1);
      expect_out("limit_buff_full", S_LIM, 1);
      expect_out("same_vs_mem", S_SAME, 0);
      drain();
      compare = 1'b1;
      expect_out("master_clears_err", S_ERR, 0);
      expect_out("master_unlock", S_LOCK, 0);
      tick();

      // mem_rst beats compare and mem_sl on the same edge
      buff_rst = 1'b1;
      tick();
      compare = 1'b1;
      expect_out("err_one", S_ERR, 1);
      tick();
      digit_in = 10'b1 << 5;
      tick();
      mem_rst = 1'b1;
      compare = 1'b1;
      mem_sl  = 1'b1;
      expect_out("rst_wins_mlen", S_MLEN, 0);
      expect_out("rst_wins_err", S_ERR, 0);
      tick();
      mem_sl = 1'b1;
      expect_out("rst_drops_pending", S_MLEN, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
